smg_scan_gen: RTL and testbench
===============================

# smg_scan_gen

Parametrised digit-strobe generator for multiplexed 7-segment displays, replacing the fixed 4-digit, 1 ms-clocked scanner. It runs from the system clock with an internal slot divider and supports any digit count. It inserts a programmable blanking (anti-ghosting) interval at the start of each slot, skips digits disabled by a runtime mask, and supports active-high or active-low strobes. It sits between the display data path, which it tells which digit to present, and the digit-select pins.

## Interface
- DIGITS, 4: number of digits (≥1).
- IDX_W, $clog2(DIGITS) (min 1): width of Digit_Idx.
- DIV, 50000: system-clock cycles per digit slot (≥2).
- BLANK, 1000: cycles at slot start with all strobes inactive (0 ≤ BLANK < DIV).
- ACTIVE_LOW, 0: 1 inverts Scan_Sig polarity.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- En  in  1  scan enable.
- Digit_Mask  in  DIGITS  bit k=1 enables digit index k.
- Scan_Sig  out  DIGITS  one-hot digit strobe; index k drives bit DIGITS-1-k (index 0 = MSB, leftmost digit).
- Digit_Idx  out  IDX_W  index of the current or next-lit digit; drives the segment mux.
- Seg_Load  out  1  one-cycle pulse on the first cycle of each slot; the data path latches the segments for Digit_Idx.
- Frame_Done  out  1  one-cycle pulse on the last cycle of the last enabled digit's slot.

## Operation
- "Inactive" means Scan_Sig = all 0 (ACTIVE_LOW=0) or all 1 (ACTIVE_LOW=1). Scan_Sig is registered.
- States: IDLE, BLANKING, ON. Slot counter cnt runs 0..DIV-1.
- IDLE: outputs inactive. The state is left when En=1 and Digit_Mask≠0.
  - Digit_Idx ← lowest enabled index.
  - cnt ← 0, Seg_Load pulses.
  - Next state is BLANKING, or ON if BLANK=0.
- BLANKING: strobes inactive while cnt < BLANK. At cnt = BLANK-1 the block moves to ON.
- ON: strobe for Digit_Idx active until cnt = DIV-1. At that cycle:
  - Next index is the next enabled index above Digit_Idx, wrapping to the lowest enabled.
  - Frame_Done pulses when the step wraps, or when the current digit is the only one enabled.
  - Next cycle: cnt ← 0, Digit_Idx ← next, Seg_Load pulses, state → BLANKING (or ON if BLANK=0).
- Digit_Mask is sampled only at slot boundaries and on IDLE exit. A digit masked mid-slot finishes its slot.
- If the mask sampled at a boundary is all zero: go to IDLE with outputs inactive, no Frame_Done. Digit_Idx holds.
- En=0 in any state: IDLE on the next cycle with strobes inactive. cnt is cleared and no pulses are issued. Re-enable restarts from the lowest enabled index.
- Exactly one strobe is ever active. There are never two adjacent digits without an intervening BLANK-cycle gap, when BLANK>0.

## Timing
- Reset values: Scan_Sig inactive, Digit_Idx=0, Seg_Load=0, Frame_Done=0, state IDLE, cnt=0.
- RST has priority over En and dominates mid-slot. Outputs are inactive on the cycle after RST is sampled high.
- Startup latency:
  - En sampled high with a nonzero mask → Seg_Load on the following cycle.
  - First strobe active BLANK+1 cycles after En is sampled (1 cycle when BLANK=0).
- Slot period is exactly DIV cycles. Frame period is DIV × popcount(mask).
- Seg_Load and Digit_Idx change on the same edge. Seg_Load precedes the strobe by BLANK cycles, giving the data path BLANK cycles to settle.
- A single enabled digit with BLANK=0 gives a strobe continuously active and Frame_Done every DIV cycles.

## Test plan
- Bench settings: DIGITS=4, DIV=10, BLANK=2, mask=4'b1111, En=1 after reset.
  - Scan_Sig: 0000×2, 1000×8, 0000×2, 0100×8, 0000×2, 0010×8, 0000×2, 0001×8, repeating.
  - Seg_Load every 10 cycles; Digit_Idx 0,1,2,3.
  - Frame_Done once per 40 cycles, on the last 0001 cycle.
- mask=4'b1010 → only indices 1 and 3 (Scan_Sig 0100, 0001). Period 20 cycles, Frame_Done every 20 cycles.
- ACTIVE_LOW=1, same stimulus as the first scenario → Scan_Sig bitwise inverted (blank = 1111, first digit = 0111).
- En dropped at cnt=5 of digit 2 → Scan_Sig inactive next cycle, no pulses. En raised → restart at index 0, Seg_Load next cycle.
- mask=0 at a boundary → IDLE, outputs inactive, no pulses. Then mask=4'b0001 with En=1 → Seg_Load next cycle, Digit_Idx=0, Scan_Sig=1000 after 2 blank cycles.
- RST pulsed during ON of digit 1 → next cycle all outputs at reset values. After release, scan restarts at index 0 with full BLANK.

Source files
------------

// File: rtl/smg_scan_gen.sv
// smg_scan_gen: digit-strobe generator for multiplexed 7-segment displays.
// Each enabled digit gets a slot of DIV system-clock cycles. The first BLANK
// cycles of a slot keep all strobes inactive so the segment data can settle
// without ghosting. After that, the one-hot strobe for Digit_Idx is driven.
// Digits cleared in Digit_Mask are skipped. The mask is sampled only at slot
// boundaries and when the scan starts from IDLE.
module smg_scan_gen #(
    parameter int DIGITS     = 4,
    parameter int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    parameter int DIV        = 50000,
    parameter int BLANK      = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              En,
    input  logic [DIGITS-1:0] Digit_Mask,
    output logic [DIGITS-1:0] Scan_Sig,
    output logic [IDX_W-1:0]  Digit_Idx,
    output logic              Seg_Load,
    output logic              Frame_Done
);

    localparam int                CNT_W      = $clog2(DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [DIGITS-1:0] INACTIVE   = {DIGITS{ACTIVE_LOW}};

    typedef enum logic [1:0] {IDLE, BLANKING, ON} state_t;

    // A slot with no blanking interval begins directly in ON.
    localparam state_t SLOT_START = (BLANK > 0) ? BLANKING : ON;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [IDX_W-1:0]   lowest_idx, above_idx;
    logic               any_enabled, above_found;
    logic [DIGITS-1:0]  strobe_nx, scan_nx;

    assign Digit_Idx   = idx;
    assign any_enabled = |Digit_Mask;

    // Find the lowest enabled digit, and the next enabled digit above the current one.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        lowest_idx  = '0;
        above_idx   = '0;
        above_found = 1'b0;
        // The scan runs downward, so the lowest matching index is written last and wins.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (Digit_Mask[k]) begin
                lowest_idx = IDX_W'(k);
                if (k > int'(idx)) begin
                    above_idx   = IDX_W'(k);
                    above_found = 1'b1;
                end
            end
        end
    end

    // State register. Scan_Sig is also registered here so that the strobe is glitch-free.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: sequential state uses non-blocking assignments so that every register samples its pre-edge value.
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            Scan_Sig <= INACTIVE;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            Scan_Sig <= scan_nx;
        end
    end

    // Next-state logic: slot counting, digit stepping and abort on En low or on an empty mask.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        if (!En) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_enabled) begin
                        state_nx = SLOT_START;
                        cnt_nx   = '0;
                        idx_nx   = lowest_idx;
                    end
                end
                BLANKING: begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == BLANK_LAST) state_nx = ON;
                end
                ON: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nx = '0;
                        if (any_enabled) begin
                            idx_nx   = above_found ? above_idx : lowest_idx;
                            state_nx = SLOT_START;
                        end else begin
                            // The digit index is kept so that it still names the last digit shown.
                            state_nx = IDLE;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output logic: the next strobe pattern, the slot-start pulse and the end-of-frame pulse.
    always_comb begin
        // Index k drives bit DIGITS-1-k, so index 0 is the leftmost digit.
        strobe_nx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            strobe_nx[DIGITS-1-k] = (idx_nx == IDX_W'(k));
        end
        scan_nx    = (state_nx == ON) ? (strobe_nx ^ INACTIVE) : INACTIVE;
        Seg_Load   = (state != IDLE) && (cnt == '0);
        // The frame ends when the step past this digit wraps round. That also covers a single enabled digit.
        Frame_Done = (state == ON) && (cnt == CNT_LAST) && En && !RST
                     && any_enabled && !above_found;
    end

endmodule

// File: tb/tb_smg_scan_gen.sv
// Bench for smg_scan_gen (DIGITS=4, DIV=10, BLANK=2). Two instances share the
// stimulus: one with active-high strobes and one with active-low strobes.
// A slot-position model predicts every cycle's outputs into a queue, and a
// monitor on the falling edge pops each prediction and compares it.
module tb_smg_scan_gen;

    localparam int DIGITS = 4;
    localparam int DIV    = 10;
    localparam int BLANK  = 2;
    localparam int WAIT_LIMIT = 200;

    logic       CLK = 1'b0;
    logic       RST;
    logic       En;
    logic [3:0] Digit_Mask;
    logic [3:0] scan_hi, scan_lo;
    logic [1:0] idx_hi, idx_lo;
    logic       seg_hi, seg_lo, fd_hi, fd_lo;

    always #5 CLK = ~CLK;

    smg_scan_gen #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK), .ACTIVE_LOW(1'b0)) dut_hi (
        .CLK(CLK), .RST(RST), .En(En), .Digit_Mask(Digit_Mask),
        .Scan_Sig(scan_hi), .Digit_Idx(idx_hi), .Seg_Load(seg_hi), .Frame_Done(fd_hi)
    );

    smg_scan_gen #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK), .ACTIVE_LOW(1'b1)) dut_lo (
        .CLK(CLK), .RST(RST), .En(En), .Digit_Mask(Digit_Mask),
        .Scan_Sig(scan_lo), .Digit_Idx(idx_lo), .Seg_Load(seg_lo), .Frame_Done(fd_lo)
    );

    typedef struct packed {
        logic [3:0] scan;
        logic [1:0] idx;
        logic       seg;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: whether a scan is running, which digit is shown, and the position inside its slot.
    bit         m_run   = 1'b0;
    int         m_digit = 0;
    int         m_pos   = 0;
    logic       rst_p   = 1'b1;
    logic       en_p    = 1'b0;
    logic [3:0] mask_p  = 4'h0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    function automatic int lowest_of(input logic [3:0] m);
        for (int k = 0; k < DIGITS; k++) if (m[k]) return k;
        return 0;
    endfunction

    function automatic bit has_above(input int d, input logic [3:0] m);
        for (int k = d + 1; k < DIGITS; k++) if (m[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int next_digit(input int d, input logic [3:0] m);
        for (int k = d + 1; k < DIGITS; k++) if (m[k]) return k;
        return lowest_of(m);
    endfunction

    // Move the model one cycle forward, using the inputs the DUT sampled at this edge.
    task automatic model_advance();
        if (rst_p) begin
            m_run   = 1'b0;
            m_digit = 0;
            m_pos   = 0;
        end else if (!en_p) begin
            m_run = 1'b0;
            m_pos = 0;
        end else if (!m_run) begin
            if (mask_p != 4'h0) begin
                m_run   = 1'b1;
                m_digit = lowest_of(mask_p);
                m_pos   = 0;
            end
        end else if (m_pos == DIV - 1) begin
            m_pos = 0;
            if (mask_p == 4'h0) m_run = 1'b0;
            else m_digit = next_digit(m_digit, mask_p);
        end else begin
            m_pos++;
        end
    endtask

    // One clock cycle: advance the model, drive the new inputs, and queue the expected outputs for this cycle.
    task automatic step(input logic rst_v, input logic en_v, input logic [3:0] mask_v);
        exp_t       e;
        logic [3:0] lit;
        @(posedge CLK);
        #1;
        model_advance();
        RST        = rst_v;
        En         = en_v;
        Digit_Mask = mask_v;
        rst_p      = rst_v;
        en_p       = en_v;
        mask_p     = mask_v;
        lit        = 4'b1000 >> m_digit;
        e.idx      = 2'(m_digit);
        if (m_run) begin
            e.scan = (m_pos >= BLANK) ? lit : 4'h0;
            e.seg  = (m_pos == 0);
            e.fd   = (m_pos == DIV - 1) && en_v && !rst_v && (mask_v != 4'h0)
                     && !has_above(m_digit, mask_v);
        end else begin
            e.scan = 4'h0;
            e.seg  = 1'b0;
            e.fd   = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare each cycle's outputs against the queued prediction, away from the active edge.
    initial begin
        exp_t       e;
        logic [3:0] inv;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                inv = ~e.scan;
                check("scan_sig",        scan_hi, e.scan);
                check("scan_sig_al",     scan_lo, inv);
                check("digit_idx",       idx_hi,  e.idx);
                check("digit_idx_al",    idx_lo,  e.idx);
                check("seg_load",        seg_hi,  e.seg);
                check("seg_load_al",     seg_lo,  e.seg);
                check("frame_done",      fd_hi,   e.fd);
                check("frame_done_al",   fd_lo,   e.fd);
            end
        end
    end

    initial begin
        int         b;
        logic [3:0] rmask;
        logic       ren, rrst;
        RST        = 1'b1;
        En         = 1'b0;
        Digit_Mask = 4'h0;

        // Reset, then a full scan of all four digits.
        repeat (3) step(1'b1, 1'b0, 4'hF);
        repeat (90) step(1'b0, 1'b1, 4'hF);

        // Only indices 1 and 3 are enabled.
        repeat (60) step(1'b0, 1'b1, 4'hA);

        // Drop En at cnt=5 of digit 2, then re-enable.
        b = 0;
        while (!(m_run && m_digit == 2 && m_pos == 4) && b < WAIT_LIMIT) begin
            step(1'b0, 1'b1, 4'hF);
            b++;
        end
        check("wait_digit2", 32'(b < WAIT_LIMIT), 32'd1);
        repeat (3) step(1'b0, 1'b0, 4'hF);
        repeat (25) step(1'b0, 1'b1, 4'hF);

        // An empty mask at a slot boundary, then a single enabled digit.
        b = 0;
        while (!(m_run && m_pos == DIV - 2) && b < WAIT_LIMIT) begin
            step(1'b0, 1'b1, 4'hF);
            b++;
        end
        check("wait_boundary", 32'(b < WAIT_LIMIT), 32'd1);
        repeat (6) step(1'b0, 1'b1, 4'h0);
        repeat (30) step(1'b0, 1'b1, 4'h1);

        // Pulse RST while digit 1 is lit.
        b = 0;
        while (!(m_run && m_digit == 1 && m_pos == 4) && b < WAIT_LIMIT) begin
            step(1'b0, 1'b1, 4'hF);
            b++;
        end
        check("wait_digit1", 32'(b < WAIT_LIMIT), 32'd1);
        step(1'b1, 1'b1, 4'hF);
        repeat (40) step(1'b0, 1'b1, 4'hF);

        // Random phase: occasional mask changes, En drops and resets.
        rmask = 4'hF;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) rmask = 4'($urandom_range(0, 15));
            ren  = ($urandom_range(0, 59) != 0);
            rrst = ($urandom_range(0, 199) == 0);
            step(rrst, ren, rmask);
        end
        repeat (5) step(1'b0, 1'b0, 4'h0);

        @(negedge CLK);
        @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
